// File: rtl/pipelined_tree_adder.sv
// Pipelined signed tree adder: an input register, log2(N_IN) registered pairwise-sum levels,
// and a packet accumulator whose result is saturated or wrapped to WIDTH with overflow flag.
module pipelined_tree_adder #(
    parameter int WIDTH    = 16,
    parameter int N_IN     = 8,
    parameter int ACC_GROW = 8,
    parameter bit SATURATE = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_IN*WIDTH-1:0]   in_data,
    input  logic                    in_last,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_ovf,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int L  = $clog2(N_IN);
    localparam int AW = WIDTH + L + ACC_GROW;

    localparam logic signed [AW-1:0] C_MAX = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] C_MIN = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0]     C_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]     C_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic w_en;
    assign w_en     = !out_valid || out_ready;
    assign in_ready = w_en;

    logic [N_IN*WIDTH-1:0] r_in_data;
    logic                  r_in_vld;
    logic                  r_in_last;

    // Input capture stage; payload is taken only from accepted beats
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_vld  <= 1'b0;
            r_in_last <= 1'b0;
            r_in_data <= '0;
        end else if (w_en) begin
            r_in_vld <= in_valid;
            if (in_valid) begin
                r_in_data <= in_data;
                r_in_last <= in_last;
            end
        end
    end

    for (genvar k = 1; k <= L; k++) begin : g_lvl
        localparam int W = WIDTH + k;
        localparam int N = N_IN >> k;
        logic signed [W-1:0] r_sum [N];
        logic signed [W-1:0] w_a   [N];
        logic signed [W-1:0] w_b   [N];
        logic                r_vld;
        logic                r_last;
        logic                w_pvld;
        logic                w_plast;

        // Each level grows by one bit so pairwise sums can never overflow
        if (k == 1) begin : g_src
            assign w_pvld  = r_in_vld;
            assign w_plast = r_in_last;
            for (genvar j = 0; j < N; j++) begin : g_pair
                assign w_a[j] = W'($signed(r_in_data[(2*j)*WIDTH +: WIDTH]));
                assign w_b[j] = W'($signed(r_in_data[(2*j+1)*WIDTH +: WIDTH]));
            end
        end else begin : g_src
            assign w_pvld  = g_lvl[k-1].r_vld;
            assign w_plast = g_lvl[k-1].r_last;
            for (genvar j = 0; j < N; j++) begin : g_pair
                assign w_a[j] = W'(g_lvl[k-1].r_sum[2*j]);
                assign w_b[j] = W'(g_lvl[k-1].r_sum[2*j+1]);
            end
        end

        // Adder level register, advancing with the global enable
        always_ff @(posedge clk) begin
            if (rst) begin
                r_vld  <= 1'b0;
                r_last <= 1'b0;
                for (int j = 0; j < N; j++) r_sum[j] <= '0;
            end else if (w_en) begin
                r_vld  <= w_pvld;
                r_last <= w_plast;
                for (int j = 0; j < N; j++) r_sum[j] <= w_a[j] + w_b[j];
            end
        end
    end

    logic signed [AW-1:0] r_acc;
    logic                 r_first;
    logic signed [AW-1:0] w_tree;
    logic signed [AW-1:0] w_sum;
    logic                 w_ovf;
    logic [WIDTH-1:0]     w_res;
    logic                 w_tvld;
    logic                 w_tlast;
    logic                 w_load;

    assign w_tree  = AW'(g_lvl[L].r_sum[0]);
    assign w_tvld  = g_lvl[L].r_vld;
    assign w_tlast = g_lvl[L].r_last;
    assign w_load  = w_en && w_tvld && w_tlast;

    // Packet sum and its conversion to the output width
    always_comb begin
        w_sum = w_tree;
        if (!r_first) begin
            w_sum = r_acc + w_tree;
        end else begin
            w_sum = w_tree;
        end
        w_ovf = (w_sum > C_MAX) || (w_sum < C_MIN);
        w_res = w_sum[WIDTH-1:0];
        if (SATURATE && w_ovf) begin
            w_res = w_sum[AW-1] ? C_NEG : C_POS;
        end else begin
            w_res = w_sum[WIDTH-1:0];
        end
    end

    // Accumulator and output register; a load wins over a consume in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_first   <= 1'b1;
            out_data  <= '0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (w_en && w_tvld) begin
                if (w_tlast) begin
                    r_acc   <= '0;
                    r_first <= 1'b1;
                end else begin
                    r_acc   <= w_sum;
                    r_first <= 1'b0;
                end
            end
            if (w_load) begin
                out_data  <= w_res;
                out_ovf   <= w_ovf;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_tree_adder.sv
// Directed bench for pipelined_tree_adder: one saturating and one wrapping instance share
// the stimulus; results are collected on handshakes and compared with hand-computed values.
module tb_pipelined_tree_adder;

    typedef logic [7:0][15:0] lanes_t;
    typedef struct {
        lanes_t      lanes;
        logic [15:0] exp_sat;
        logic [15:0] exp_wrap;
        logic        exp_ovf;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] in_data;
    logic         in_last;
    logic         in_valid;
    logic         in_ready;
    logic         in_ready_w;
    logic [15:0]  out_data;
    logic [15:0]  out_data_w;
    logic         out_ovf;
    logic         out_ovf_w;
    logic         out_valid;
    logic         out_valid_w;
    logic         out_ready;
    logic         man_rdy  = 1'b1;
    logic         rand_rdy = 1'b1;
    logic         use_rand = 1'b0;

    int checks   = 0;
    int failures = 0;
    int cycle_cnt = 0;

    logic [15:0] q_sd[$];
    logic [15:0] q_wd[$];
    logic        q_so[$];
    logic        q_wo[$];

    vec_t vecs[9];

    always #5 clk = ~clk;
    assign out_ready = use_rand ? rand_rdy : man_rdy;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    always @(posedge clk) begin
        #1;
        rand_rdy = 1'($urandom_range(0, 1));
    end

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            q_sd.push_back(out_data);
            q_so.push_back(out_ovf);
        end
        if (!rst && out_valid_w && out_ready) begin
            q_wd.push_back(out_data_w);
            q_wo.push_back(out_ovf_w);
        end
    end

    pipelined_tree_adder #(.WIDTH(16), .N_IN(8), .ACC_GROW(8), .SATURATE(1'b1)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_last(in_last), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_ovf(out_ovf), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    pipelined_tree_adder #(.WIDTH(16), .N_IN(8), .ACC_GROW(8), .SATURATE(1'b0)) dut_w (
        .clk(clk), .rst(rst), .in_data(in_data), .in_last(in_last), .in_valid(in_valid),
        .in_ready(in_ready_w), .out_data(out_data_w), .out_ovf(out_ovf_w), .out_valid(out_valid_w),
        .out_ready(out_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic lanes_t fill(input logic [15:0] v);
        lanes_t l;
        for (int i = 0; i < 8; i++) l[i] = v;
        return l;
    endfunction

    task automatic send(input lanes_t lanes, input logic last, output int acc_cyc);
        bit done = 1'b0;
        acc_cyc  = -1;
        in_data  = lanes;
        in_last  = last;
        in_valid = 1'b1;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            tick();
        end
        acc_cyc = cycle_cnt;
        chk("send_accept", 32'(done), 32'd1);
        in_valid = 1'b0;
        in_data  = {8{16'h5A5A}};
        in_last  = 1'b1;
    endtask

    task automatic wait_results(input string name, input int n);
        for (int t = 0; t < 300 && q_sd.size() < n; t++) tick();
        repeat (8) tick();
        chk({name, "_count_sat"}, 32'(q_sd.size()), 32'(n));
        chk({name, "_count_wrap"}, 32'(q_wd.size()), 32'(n));
    endtask

    task automatic pop_chk(input string name, input logic [15:0] es, input logic [15:0] ew,
                           input logic eo);
        chk({name, "_present"}, 32'(q_sd.size() != 0 && q_wd.size() != 0), 32'd1);
        if (q_sd.size() != 0 && q_wd.size() != 0) begin
            chk({name, "_data_sat"}, 32'(q_sd.pop_front()), 32'(es));
            chk({name, "_ovf_sat"}, 32'(q_so.pop_front()), 32'(eo));
            chk({name, "_data_wrap"}, 32'(q_wd.pop_front()), 32'(ew));
            chk({name, "_ovf_wrap"}, 32'(q_wo.pop_front()), 32'(eo));
        end
    endtask

    task automatic clear_q();
        q_sd.delete();
        q_so.delete();
        q_wd.delete();
        q_wo.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        lanes_t l;
        int     a;
        int     lat;

        for (int i = 0; i < 8; i++) l[i] = 16'(i + 1);
        vecs[0] = '{l, 16'h0024, 16'h0024, 1'b0};
        vecs[1] = '{fill(16'h7FFF), 16'h7FFF, 16'hFFF8, 1'b1};
        vecs[2] = '{fill(16'h8000), 16'h8000, 16'h0000, 1'b1};
        vecs[3] = '{fill(16'hFFFD), 16'hFFE8, 16'hFFE8, 1'b0};
        l = '0; l[0] = 16'h7FFF;
        vecs[4] = '{l, 16'h7FFF, 16'h7FFF, 1'b0};
        l[1] = 16'h0001;
        vecs[5] = '{l, 16'h7FFF, 16'h8000, 1'b1};
        l = '0; l[0] = 16'h8000;
        vecs[6] = '{l, 16'h8000, 16'h8000, 1'b0};
        l[1] = 16'hFFFF;
        vecs[7] = '{l, 16'h8000, 16'h7FFF, 1'b1};
        l = '{16'd0, 16'd3, 16'hFC18, 16'd1000, 16'hFFF9, 16'd7, 16'hFFCE, 16'd100};
        vecs[8] = '{l, 16'h0035, 16'h0035, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data", 32'(out_data), 32'd0);
        chk("reset_out_ovf", 32'(out_ovf), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        // Single beat: latency and one-cycle valid pulse
        for (int i = 0; i < 8; i++) l[i] = 16'(i + 1);
        send(l, 1'b1, a);
        lat = -1;
        for (int t = 0; t < 20 && lat < 0; t++) begin
            @(negedge clk);
            if (out_valid) lat = cycle_cnt - a;
        end
        chk("latency", 32'(lat), 32'd4);
        @(negedge clk);
        chk("valid_one_cycle", 32'(out_valid), 32'd0);
        tick();
        pop_chk("single_36", 16'h0024, 16'h0024, 1'b0);
        clear_q();

        // Table of single-beat packets under random backpressure
        use_rand = 1'b1;
        for (int i = 0; i < 9; i++) send(vecs[i].lanes, 1'b1, a);
        use_rand = 1'b0;
        man_rdy  = 1'b1;
        wait_results("table", 9);
        for (int i = 0; i < 9; i++)
            pop_chk($sformatf("vec%0d", i), vecs[i].exp_sat, vecs[i].exp_wrap, vecs[i].exp_ovf);
        clear_q();

        // Multi-beat packet followed by a fresh packet
        send(fill(16'h0001), 1'b0, a);
        send(fill(16'h0001), 1'b0, a);
        send(fill(16'h0001), 1'b1, a);
        send(fill(16'hFFFD), 1'b1, a);
        wait_results("multi", 2);
        pop_chk("multi_24", 16'h0018, 16'h0018, 1'b0);
        pop_chk("fresh_m24", 16'hFFE8, 16'hFFE8, 1'b0);
        clear_q();

        // Stall with five packets in flight, then drain in order
        man_rdy = 1'b0;
        for (int k = 1; k <= 5; k++) send(fill(16'(k)), 1'b1, a);
        repeat (10) tick();
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_in_ready_w", 32'(in_ready_w), 32'd0);
        chk("stall_no_output", 32'(q_sd.size()), 32'd0);
        man_rdy = 1'b1;
        wait_results("drain", 5);
        for (int k = 1; k <= 5; k++)
            pop_chk($sformatf("drain%0d", k), 16'(8 * k), 16'(8 * k), 1'b0);
        clear_q();

        // Reset in the middle of a packet
        send(fill(16'h0005), 1'b0, a);
        send(fill(16'h0005), 1'b0, a);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        send(fill(16'h0002), 1'b1, a);
        wait_results("abort", 1);
        pop_chk("abort_16", 16'h0010, 16'h0010, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
